// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcodes, FSM states,
// and the bit-counter width rule.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in, serial-out shift register. It shifts right, so the LSB is
// presented first. A load takes priority over a shift.
module shift_reg_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = data_q >> 1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign lsb = data_q[0];

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: steps two WIDTH-bit operands LSB-first through an
// external combinational one-bit ALU slice and reassembles the result.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             F1,
  output logic             F0,
  output logic             A,
  output logic             B,
  output logic             cin,
  input  logic             F,
  input  logic             Cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q,  state_d;
  logic [1:0]       op_q,     op_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;

  logic load;
  logic shift;
  logic a_bit;
  logic b_bit;

  shift_reg_piso #(.WIDTH(WIDTH)) u_a_sh (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (a),
    .lsb   (a_bit)
  );

  shift_reg_piso #(.WIDTH(WIDTH)) u_b_sh (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (b),
    .lsb   (b_bit)
  );

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    load     = 1'b0;
    shift    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          op_d    = op;
          carry_d = (op == OP_ADD) ? carry_in : 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        shift    = 1'b1;
        // Result fills from the MSB side; after WIDTH shifts bit 0 sits at the LSB.
        result_d = result_q >> 1;
        result_d[WIDTH-1] = F;
        carry_d  = (op_q == OP_ADD) ? Cout : 1'b0;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = carry_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Slice inputs are forced low outside RUN; the function select always shows the latched op.
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign F1     = op_q[1];
  assign F0     = op_q[0];
  assign A      = busy & a_bit;
  assign B      = busy & b_bit;
  assign cin    = busy & carry_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq: an 8-bit and a 1-bit instance, each
// driving a behavioural one-bit ALU slice.
module tb_serial_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  exp_t q8[$];
  exp_t q1[$];

  // 8-bit instance signals
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = '0, b = '0;
  logic       carry_in = 1'b0;
  logic       busy, done, cout;
  logic [7:0] result;
  logic       f1, f0, sa, sb, scin, sf, scout;

  // 1-bit instance signals
  logic       start1 = 1'b0;
  logic [1:0] op1 = 2'b00;
  logic [0:0] a1 = '0, b1 = '0;
  logic       carry_in1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] result1;
  logic       f1_1, f0_1, sa1, sb1, scin1, sf1, scout1;

  serial_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .carry_in(carry_in), .busy(busy), .done(done), .result(result),
    .cout(cout), .F1(f1), .F0(f0), .A(sa), .B(sb), .cin(scin),
    .F(sf), .Cout(scout)
  );

  serial_alu_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
    .carry_in(carry_in1), .busy(busy1), .done(done1), .result(result1),
    .cout(cout1), .F1(f1_1), .F0(f0_1), .A(sa1), .B(sb1), .cin(scin1),
    .F(sf1), .Cout(scout1)
  );

  // Behavioural slice: AND / OR / XOR / full adder.
  always_comb begin
    sf = 1'b0; scout = 1'b0;
    case ({f1, f0})
      2'b00: sf = sa & sb;
      2'b01: sf = sa | sb;
      2'b10: sf = sa ^ sb;
      default: begin
        sf    = sa ^ sb ^ scin;
        scout = (sa & sb) | (scin & (sa ^ sb));
      end
    endcase
  end

  always_comb begin
    sf1 = 1'b0; scout1 = 1'b0;
    case ({f1_1, f0_1})
      2'b00: sf1 = sa1 & sb1;
      2'b01: sf1 = sa1 | sb1;
      2'b10: sf1 = sa1 ^ sb1;
      default: begin
        sf1    = sa1 ^ sb1 ^ scin1;
        scout1 = (sa1 & sb1) | (scin1 & (sa1 ^ sb1));
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitors: pop an expectation whenever a done pulse appears.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done === 1'b1) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", {31'b0, done}, 32'd0);
      end else begin
        e = q8.pop_front();
        check("result8", {24'b0, result}, {24'b0, e.res});
        check("cout8", {31'b0, cout}, {31'b0, e.c});
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("unexpected_done1", {31'b0, done1}, 32'd0);
      end else begin
        e = q1.pop_front();
        check("result1", {31'b0, result1}, {31'b0, e.res[0]});
        check("cout1", {31'b0, cout1}, {31'b0, e.c});
      end
    end
  end

  // One full operation on the 8-bit instance with cycle-exact handshake checks.
  task automatic run_op(input logic [1:0] o, input logic [7:0] ai, input logic [7:0] bi,
                        input logic ci, input logic [7:0] er, input logic ec);
    @(negedge clk);
    op = o; a = ai; b = bi; carry_in = ci; start = 1'b1;
    q8.push_back('{res: er, c: ec});
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("busy_run", {31'b0, busy}, 32'd1);
      check("done_run", {31'b0, done}, 32'd0);
      check("fsel_run", {30'b0, f1, f0}, {30'b0, o});
    end
    @(negedge clk);
    check("done_cycle9", {31'b0, done}, 32'd1);
    check("busy_in_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("result_held", {24'b0, result}, {24'b0, er});
  endtask

  initial begin
    int t1, t2;
    #1 rst = 1'b1;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", {24'b0, result}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_slice_in", {27'b0, f1, f0, sa, sb, scin}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(OP_ADD, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op(OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op(OP_ADD, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    run_op(OP_AND, 8'hA5, 8'h0F, 1'b1, 8'h05, 1'b0);
    run_op(OP_OR,  8'hA5, 8'h0F, 1'b1, 8'hAF, 1'b0);
    run_op(OP_XOR, 8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0);

    // start held high; a changes mid-operation and only affects the second op.
    @(negedge clk);
    op = OP_ADD; a = 8'h5A; b = 8'h3C; carry_in = 1'b0; start = 1'b1;
    q8.push_back('{res: 8'h96, c: 1'b0});
    q8.push_back('{res: 8'h4D, c: 1'b0});
    t1 = -1; t2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) a = 8'h11;
      if (k == 12) start = 1'b0;
      if (done) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
    end
    check("hold_first_done", t1, 32'd9);
    check("hold_done_gap", t2 - t1, 32'd10);

    // Reset during cycle 4 aborts; no done pulse may follow.
    @(negedge clk);
    op = OP_ADD; a = 8'h5A; b = 8'h3C; carry_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", {24'b0, result}, 32'd0);
    check("abort_cout", {31'b0, cout}, 32'd0);
    check("abort_slice_in", {27'b0, f1, f0, sa, sb, scin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_done", {31'b0, done}, 32'd0);
    end
    run_op(OP_ADD, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // WIDTH=1 instance
    @(negedge clk);
    op1 = OP_ADD; a1 = 1'b1; b1 = 1'b1; carry_in1 = 1'b1; start1 = 1'b1;
    q1.push_back('{res: 8'h01, c: 1'b1});
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    check("w1_busy_c1", {31'b0, busy1}, 32'd1);
    check("w1_done_c1", {31'b0, done1}, 32'd0);
    @(negedge clk);
    check("w1_done_c2", {31'b0, done1}, 32'd1);
    @(negedge clk);
    check("w1_done_end", {31'b0, done1}, 32'd0);

    repeat (2) @(negedge clk);
    check("sb8_drained", q8.size(), 32'd0);
    check("sb1_drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial ALU sequencer that drives the existing one-bit ALU slice (ports F0, F1, A, B, cin in; F, Cout out). It accepts parallel WIDTH-bit operands and an opcode through a start/done handshake. It then steps the operands through the slice one bit per clock, LSB first, carrying Cout back into cin. It assembles the result and final carry. It sits between the control logic and the combinational slice; the slice stays outside this block.

## Interface
- WIDTH, default 8, operand/result width in bits (legal ≥ 1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  opcode {F1,F0}: 00 AND, 01 OR, 10 XOR, 11 ADD
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- carry_in  input  1  initial carry for ADD, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result/cout valid
- result  output  WIDTH  assembled result, held until next accepted start
- cout  output  1  final carry (ADD only; 0 for logic ops)
- F1, F0  output  1 each  slice function select
- A, B  output  1 each  current operand bits to slice
- cin  output  1  carry to slice
- F  input  1  slice result bit (combinational from A,B,cin,F1,F0)
- Cout  input  1  slice carry out

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: at the clock edge, load a and b into shift registers and latch op. Set carry register = carry_in if op==11, else 0. Clear the bit counter to 0. Go to RUN.
- RUN, each cycle:
  - Drive A=a_sh[0], B=b_sh[0], {F1,F0}=op, cin=carry.
  - At the edge, shift F into the result register from the MSB side (shift right) and shift both operand registers right.
  - If op==11, set carry ← Cout; otherwise carry stays 0.
  - Increment the counter. When counter==WIDTH-1, go to DONE.
- DONE: done=1 and cout=carry. Go to IDLE at the next edge.
- start is ignored in RUN and DONE; no queueing.
- Outside RUN: A=B=cin=0 and {F1,F0}=latched op.
- The slice is purely combinational; F and Cout are sampled in the same cycle they are driven.
- Arithmetic: ADD result = (a+b+carry_in) mod 2^WIDTH, with cout = bit WIDTH of the sum. AND, OR and XOR are bitwise, with cout=0.

## Timing
- Reset (async, immediate): state=IDLE, busy=0, done=0, result=0, cout=0, carry=0, counter=0, and A=B=cin=F0=F1=0.
- Latency:
  - Start is sampled at edge 0.
  - busy=1 during cycles 1..WIDTH.
  - done=1 during cycle WIDTH+1.
  - The earliest next start is sampled at the edge ending cycle WIDTH+1 is not accepted (still DONE). The first acceptable start is sampled at the edge ending cycle WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- result changes only on RUN edges. It is stable and valid from the done cycle until the first RUN edge of the next operation.
- cout updates only on entry to DONE.
- Reset asserted mid-RUN aborts the operation: outputs take reset values, and no done pulse is produced.
- WIDTH=1: a single RUN cycle, then DONE.

## Structure
- Shared package `alu_pkg`:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11
  - FSM state encoding (IDLE, RUN, DONE)
- One sub-module: `shift_reg_piso`, a parameterized WIDTH parallel-load, shift-right register. It is instantiated twice, for a and b.
- The counter is $clog2(WIDTH) bits wide, minimum 1.
- The bench supplies a behavioural slice model matching the opcode table. ADD is a full adder. Cout=0 for the logic ops.

## Test plan
- ADD, WIDTH=8, a=8'h5A, b=8'h3C, carry_in=0 → result=8'h96, cout=0, done exactly at cycle 9, busy high for cycles 1–8.
- ADD a=8'hFF, b=8'h01, carry_in=0 → result=8'h00, cout=1. Then ADD a=8'h00, b=8'h00, carry_in=1 → result=8'h01, cout=0.
- AND/OR/XOR with a=8'hA5, b=8'h0F → 8'h05 / 8'hAF / 8'hAA respectively, cout=0 each. Check that F1,F0 match op throughout RUN.
- Hold start high continuously with a changing to 8'h11 mid-operation → the first op completes with its original operands. The next op is accepted only in IDLE (done pulses spaced 10 cycles apart).
- Assert rst during cycle 4 of an ADD → all outputs are 0 immediately, there is no done pulse, and a fresh start afterwards completes correctly.
- WIDTH=1, ADD a=1, b=1, carry_in=1 → result=1, cout=1, done at cycle 2.
